i2c_slave_mem: RTL and testbench
================================

# i2c_slave_mem

Synthesizable I2C responder that models a two-byte-addressed serial EEPROM (AT24C64-style command set) in RTL. It lets the I2C master controller be exercised on hardware and in simulation against a real target rather than a behavioural model. It oversamples SCL/SDA with the system clock, drives SDA open-drain, and holds a small internal byte memory. It supports byte/page write, current-address read, random read and sequential read.

## Interface
- DEV_ADDR, 7'h50, 7-bit device address; write byte 8'hA0, read byte 8'hA1
- MEM_AW, 8, internal memory address width; depth 2^MEM_AW bytes
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- i2c_sclk  input  1  SCL from bus, asynchronous to clk
- i2c_sdat_in  input  1  SDA as read from bus pad
- i2c_sdat_oe  output  1  1 = pull SDA low; 0 = release; pad is tristate, never drives high
- bus_busy  output  1  high from START until STOP
- wr_strobe  output  1  one-clk pulse per byte written into memory
- wr_addr  output  MEM_AW  address of the byte written, valid with wr_strobe
- wr_data  output  8  data written, valid with wr_strobe

## Operation
- Input conditioning: SCL and SDA each pass through a 2-FF synchronizer plus one history FF.
  - scl_rise/scl_fall are one-clk pulses.
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
- Data sampling and driving:
  - Sample SDA on scl_rise.
  - Change i2c_sdat_oe only on scl_fall, except that STOP/START release it immediately.
- Bit counter: 3 bits, cleared on START and after each ACK slot; MSB first.
- States and transitions:
  - IDLE: wait for START.
  - DEV: shift 8 bits.
    - Upper 7 bits == DEV_ADDR → DEV_ACK.
    - Otherwise → IGNORE; no ACK; wait for next START/STOP.
  - DEV_ACK: drive ACK.
    - R/W=0 → ADDR_HI.
    - R/W=1 → RD_DATA.
  - ADDR_HI → ACK → ADDR_LO → ACK → WR_DATA.
    - Pointer = {hi, lo} truncated to the low MEM_AW bits; bits above MEM_AW are ignored.
  - WR_DATA: on 8th bit, write the byte to mem[pointer] and pulse wr_strobe; then ACK, pointer+1, stay in WR_DATA.
  - RD_DATA: present mem[pointer] MSB first; after the 8th bit release SDA → RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (0) → pointer+1, next byte.
    - NACK (1) → IGNORE.
- ACK slot: on scl_fall after the 8th bit, oe=1; on the following scl_fall, oe=0. For a read continuing after DEV_ACK, oe = ~data[7] instead.
- Pointer:
  - Wraps modulo 2^MEM_AW, with no page boundary.
  - Retained across repeated START and STOP.
  - Cleared only by reset.
- Random read: write phase sets the pointer (DEV, ADDR_HI, ADDR_LO), then repeated START with R/W=1 reads from that pointer.
- START in any state (repeated START) → DEV, bit counter cleared, oe=0.
- STOP in any state → IDLE, oe=0.
  - A partial data byte (<8 bits) is discarded, not written.
- Memory contents are not reset; reading a never-written location returns undefined data.

## Timing
- Reset values: i2c_sdat_oe=0, bus_busy=0, wr_strobe=0, wr_addr=0, wr_data=0, state IDLE, pointer 0.
- Latency from bus edge to internal pulse: 3 clk (2 sync + 1 edge).
  - Example: oe asserts 4 clk after the SCL falling edge on the pin.
- Bus requirements:
  - SCL high and low phases each ≥ 8 clk.
  - SDA setup/hold relative to SCL ≥ 4 clk.
  - Faster buses are unsupported.
- wr_strobe is asserted for exactly 1 clk, 1 clk after the scl_rise of the 8th data bit. wr_addr/wr_data are valid in that cycle and hold until the next write.
- bus_busy rises 1 clk after START detect and falls 1 clk after STOP detect.
- Simultaneous STOP and scl_fall cannot occur, since STOP needs SCL high. START/STOP take priority over bit processing in the same cycle.
- Reset mid-transfer: immediate release of SDA; the next START is required before any response.

## Test plan
- Byte write: START, A0, 00, 0F, data 0F, STOP → ACK on all 4 bytes; wr_strobe once with wr_addr=0x0F, wr_data=0x0F.
- Random read: write pointer 00/0F, repeated START, A1, read one byte, master NACK, STOP → byte 0x0F returned; SDA released after NACK.
- Sequential write/read with wrap: write 0xAA, 0xBB, 0xCC starting at 0x00FE; sequential read from 0x00FE → 0xAA, 0xBB, 0xCC with addresses 0xFE, 0xFF, 0x00.
- Address mismatch: START, 0xA4 → no ACK (oe stays 0 through the 9th clock); subsequent bytes ignored until START; wr_strobe never fires.
- Aborted write: STOP after 5 data bits → no wr_strobe; a following current-address read returns the previous contents.
- Async reset asserted during RD_DATA while oe=1 → oe=0 and bus_busy=0 within the reset assertion; after release, a full byte write to 0x0010 succeeds.

Source files
------------

// File: rtl/i2c_slave_mem_if.sv
// I2C target-side bus bundle: SCL/SDA pad signals plus the memory write
// observation port of the EEPROM responder.
interface i2c_slave_mem_if #(
  parameter int unsigned MEM_AW = 8
);
  logic              i2c_sclk;
  logic              i2c_sdat_in;
  logic              i2c_sdat_oe;
  logic              bus_busy;
  logic              wr_strobe;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  i2c_sclk, i2c_sdat_in,
    output i2c_sdat_oe, bus_busy, wr_strobe, wr_addr, wr_data
  );

  modport master (
    output i2c_sclk, i2c_sdat_in,
    input  i2c_sdat_oe, bus_busy, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_slave_mem.sv
// Two-byte-addressed serial EEPROM responder (AT24C64-style command set).
// SCL/SDA are oversampled with clk; SDA is only ever pulled low.
module i2c_slave_mem #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  i2c_slave_mem_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV, ST_DEV_ACK, ST_ADDR_HI, ST_AHI_ACK, ST_ADDR_LO,
    ST_ALO_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_REL, ST_RD_ACK,
    ST_RD_NEXT, ST_IGNORE
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              mem_we;
  logic [7:0]        rx_byte;
  logic [7:0]        rd_byte;
  logic [15:0]       addr_full;
  logic [7:0]        mem [2**MEM_AW];

  // Synchronize the bus lines and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= bus.i2c_sclk;  scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= bus.i2c_sdat_in; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  assign scl_rise  =  scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q &  scl_h_q;
  assign start_det =  scl_s2_q &  scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  =  scl_s2_q &  scl_h_q & ~sda_h_q & sda_s2_q;

  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = mem[ptr_q];
  assign addr_full = {addr_hi_q, rx_byte};

  // Protocol state machine: next state, pointer, SDA drive and write pulse
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_hi_d   = addr_hi_q;
    ptr_d       = ptr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    if (start_det) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_DEV:     state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                ST_ADDR_HI: begin addr_hi_d = rx_byte; state_d = ST_AHI_ACK; end
                ST_ADDR_LO: begin ptr_d = MEM_AW'(addr_full); state_d = ST_ALO_ACK; end
                default: begin
                  mem_we      = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = rx_byte;
                  ptr_d       = ptr_q + MEM_AW'(1);
                  state_d     = ST_WR_ACK;
                end
              endcase
            end
          end
        end
        // oe_q doubles as the ACK phase flag: low on entry, set on the first fall
        ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                ST_DEV_ACK: begin
                  if (shift_q[0]) begin
                    shift_d = rd_byte;
                    oe_d    = ~rd_byte[7];
                    state_d = ST_RD_DATA;
                  end else begin
                    state_d = ST_ADDR_HI;
                  end
                end
                ST_AHI_ACK: state_d = ST_ADDR_LO;
                default:    state_d = ST_WR_DATA;
              endcase
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_RD_REL;
          end else if (scl_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        ST_RD_REL: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = ST_RD_ACK;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              ptr_d   = ptr_q + MEM_AW'(1);
              state_d = ST_RD_NEXT;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_RD_NEXT: begin
          if (scl_fall) begin
            shift_d   = rd_byte;
            oe_d      = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_hi_q   <= '0;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_hi_q   <= addr_hi_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Byte storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  assign bus.i2c_sdat_oe = oe_q;
  assign bus.bus_busy    = busy_q;
  assign bus.wr_strobe   = wr_strobe_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Scoreboard bench for i2c_slave_mem: a bit-banged I2C master drives the bus,
// expected writes/reads are queued at stimulus time and popped on DUT output.
module tb_i2c_slave_mem;

  localparam int unsigned T = 10;  // clk cycles per SCL phase

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda_low = 1'b0;

  i2c_slave_mem_if #(.MEM_AW(8)) bus ();
  assign bus.i2c_sdat_in = ~(m_sda_low | bus.i2c_sdat_oe);

  always #5 clk = ~clk;

  i2c_slave_mem #(.DEV_ADDR(7'h50), .MEM_AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start;
    m_sda_low = 1'b0; tick(5);
    bus.i2c_sclk = 1'b1; tick(T);
    m_sda_low = 1'b1; tick(T);
    bus.i2c_sclk = 1'b0;
  endtask

  task automatic bus_stop;
    tick(5); m_sda_low = 1'b1; tick(T);
    bus.i2c_sclk = 1'b1; tick(T);
    m_sda_low = 1'b0; tick(T);
  endtask

  task automatic put_bit(input logic b);
    tick(5); m_sda_low = ~b; tick(T);
    bus.i2c_sclk = 1'b1; tick(T);
    bus.i2c_sclk = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(5); m_sda_low = 1'b0; tick(T);
    bus.i2c_sclk = 1'b1; tick(T / 2);
    b = bus.i2c_sdat_in;
    tick(T - T / 2);
    bus.i2c_sclk = 1'b0;
  endtask

  // ack_exp=1: target must pull SDA low in the 9th clock; 0: line must stay high
  task automatic write_byte(input logic [7:0] b, input logic ack_exp, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    check_val(tag, {31'd0, a}, {31'd0, ~ack_exp});
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~m_ack);
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
    exp_wr_q.push_back(wr_t'{addr: a, data: d});
  endtask

  task automatic read_check(input logic m_ack, input string tag);
    logic [7:0] d;
    read_byte(m_ack, d);
    check_val(tag, {24'd0, d}, {24'd0, exp_rd_q.pop_front()});
  endtask

  task automatic set_pointer(input logic [7:0] hi, input logic [7:0] lo, input string tag);
    bus_start;
    write_byte(8'hA0, 1'b1, {tag, "_dev"});
    write_byte(hi, 1'b1, {tag, "_ahi"});
    write_byte(lo, 1'b1, {tag, "_alo"});
  endtask

  // Write monitor: every strobe must match the oldest queued expected write
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (rst_n && bus.wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_wr_q.pop_front();
        check_val("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
        check_val("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i2c_sclk = 1'b1;
    tick(3);
    check_val("rst_oe",   {31'd0, bus.i2c_sdat_oe}, 32'd0);
    check_val("rst_busy", {31'd0, bus.bus_busy},    32'd0);
    check_val("rst_wstb", {31'd0, bus.wr_strobe},   32'd0);
    check_val("rst_wadr", {24'd0, bus.wr_addr},     32'd0);
    check_val("rst_wdat", {24'd0, bus.wr_data},     32'd0);
    rst_n = 1'b1;
    tick(5);

    // Byte write 0x0F -> 0x000F
    set_pointer(8'h00, 8'h0F, "bw");
    check_val("bw_busy", {31'd0, bus.bus_busy}, 32'd1);
    exp_write(8'h0F, 8'h0F);
    write_byte(8'h0F, 1'b1, "bw_data");
    bus_stop;
    check_val("bw_busy_end", {31'd0, bus.bus_busy}, 32'd0);

    // Random read of 0x000F, master NACK
    set_pointer(8'h00, 8'h0F, "rr");
    bus_start;
    write_byte(8'hA1, 1'b1, "rr_rdev");
    exp_rd_q.push_back(8'h0F);
    read_check(1'b0, "rr_data");
    tick(5);
    check_val("rr_release", {31'd0, bus.i2c_sdat_oe}, 32'd0);
    bus_stop;

    // Sequential write across the pointer wrap
    set_pointer(8'h00, 8'hFE, "sw");
    exp_write(8'hFE, 8'hAA); write_byte(8'hAA, 1'b1, "sw_d0");
    exp_write(8'hFF, 8'hBB); write_byte(8'hBB, 1'b1, "sw_d1");
    exp_write(8'h00, 8'hCC); write_byte(8'hCC, 1'b1, "sw_d2");
    bus_stop;

    // Sequential read across the wrap
    set_pointer(8'h00, 8'hFE, "sr");
    bus_start;
    write_byte(8'hA1, 1'b1, "sr_rdev");
    exp_rd_q.push_back(8'hAA); exp_rd_q.push_back(8'hBB); exp_rd_q.push_back(8'hCC);
    read_check(1'b1, "sr_d0");
    read_check(1'b1, "sr_d1");
    read_check(1'b0, "sr_d2");
    bus_stop;

    // Address mismatch: no ACK, following bytes ignored, no writes
    bus_start;
    write_byte(8'hA4, 1'b0, "mm_dev");
    check_val("mm_oe", {31'd0, bus.i2c_sdat_oe}, 32'd0);
    write_byte(8'h00, 1'b0, "mm_b1");
    write_byte(8'h55, 1'b0, "mm_b2");
    bus_stop;

    // Aborted write: 5 data bits then STOP must not modify 0x0020
    set_pointer(8'h00, 8'h20, "ab_pre");
    exp_write(8'h20, 8'h5A);
    write_byte(8'h5A, 1'b1, "ab_pre_data");
    bus_stop;
    set_pointer(8'h00, 8'h20, "ab");
    put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    bus_stop;
    bus_start;
    write_byte(8'hA1, 1'b1, "ab_rdev");
    exp_rd_q.push_back(8'h5A);
    read_check(1'b0, "ab_data");
    bus_stop;

    // Reset in the middle of a read while SDA is pulled low
    set_pointer(8'h00, 8'h0F, "rs");
    bus_start;
    write_byte(8'hA1, 1'b1, "rs_rdev");
    tick(8);
    check_val("rs_oe_pre", {31'd0, bus.i2c_sdat_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rs_oe",   {31'd0, bus.i2c_sdat_oe}, 32'd0);
    check_val("rs_busy", {31'd0, bus.bus_busy},    32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    set_pointer(8'h00, 8'h10, "pr");
    exp_write(8'h10, 8'h77);
    write_byte(8'h77, 1'b1, "pr_data");
    bus_stop;
    set_pointer(8'h00, 8'h10, "pr_rb");
    bus_start;
    write_byte(8'hA1, 1'b1, "pr_rb_rdev");
    exp_rd_q.push_back(8'h77);
    read_check(1'b0, "pr_rb_data");
    bus_stop;

    tick(20);
    check_val("wr_q_left", exp_wr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
